// File: rtl/lcd_escritor.sv
// Drives an 11-byte word (palavra + RS_list) into an HD44780-style 8-bit LCD.
// Define LCD_INIT_EN to add the power-up wait and init command sequence.
module lcd_escritor #(
  parameter int E_SETUP_CYC      = 2,
  parameter int E_PULSE_CYC      = 25,
  parameter int CMD_WAIT_CYC     = 2000,
  parameter int LONG_WAIT_CYC    = 82000,
  parameter int POWERUP_WAIT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [87:0] palavra,
  input  logic [10:0] RS_list,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e,
  output logic        busy,
  output logic        done
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int SETUP_N   = max2(E_SETUP_CYC, 1);
  localparam int PULSE_N   = max2(E_PULSE_CYC, 1);
  localparam int CMD_N     = max2(CMD_WAIT_CYC, 1);
  localparam int LONG_N    = max2(LONG_WAIT_CYC, 1);
  localparam int POWERUP_N = max2(POWERUP_WAIT_CYC, 1);
  localparam int MAX_N     = max2(max2(max2(SETUP_N, PULSE_N), max2(CMD_N, LONG_N)), POWERUP_N);
  localparam int CW        = $clog2(MAX_N) + 1;

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_N - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_N - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_N - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_N - 1);
`ifdef LCD_INIT_EN
  localparam logic [CW-1:0] POWERUP_LAST = CW'(POWERUP_N - 1);
`endif

  typedef enum logic [2:0] {
    S_POWERUP, S_INIT, S_IDLE, S_SETUP, S_PULSE, S_WAIT, S_NEXT, S_DONE
  } state_t;

  function automatic logic [7:0] init_cmd(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h38;
      4'd1:    return 8'h0C;
      4'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [87:0]   word_q, word_d;
  logic [10:0]   rs_list_q, rs_list_d;
  logic          init_q, init_d;
  logic [7:0]    lcd_data_q, lcd_data_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic          lcd_e_q, lcd_e_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load_byte;
  logic [CW-1:0] wait_last;

  // Clear-display and return-home commands need the long execution wait.
  assign wait_last = (!lcd_rs_q && (lcd_data_q == 8'h01 || lcd_data_q == 8'h02))
                     ? LONG_LAST : CMD_LAST;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    word_d     = word_q;
    rs_list_d  = rs_list_q;
    init_d     = init_q;
    lcd_data_d = lcd_data_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_e_d    = lcd_e_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_byte  = 1'b0;

    case (state_q)
`ifdef LCD_INIT_EN
      S_POWERUP: begin
        if (cnt_q == POWERUP_LAST) begin
          cnt_d   = '0;
          state_d = S_INIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_INIT: begin
        init_d    = 1'b1;
        idx_d     = 4'd0;
        load_byte = 1'b1;
        state_d   = S_SETUP;
      end
`endif
      S_IDLE: begin
        if (start) begin
          word_d    = palavra;
          rs_list_d = RS_list;
          idx_d     = 4'd0;
          init_d    = 1'b0;
          busy_d    = 1'b1;
          load_byte = 1'b1;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          lcd_e_d = 1'b1;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          lcd_e_d = 1'b0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d   = '0;
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_NEXT: begin
        if (init_q && idx_q == 4'd3) begin
          init_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (!init_q && idx_q == 4'd10) begin
          state_d = S_DONE;
        end else begin
          idx_d     = idx_q + 4'd1;
          load_byte = 1'b1;
          state_d   = S_SETUP;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Byte and RS are registered on entry to SETUP and held through PULSE and WAIT.
    if (load_byte) begin
      lcd_data_d = init_d ? init_cmd(idx_d) : word_d[{idx_d, 3'b000} +: 8];
      lcd_rs_d   = init_d ? 1'b0 : rs_list_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef LCD_INIT_EN
      state_q <= S_POWERUP;
      busy_q  <= 1'b1;
`else
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
`endif
      cnt_q      <= '0;
      idx_q      <= 4'd0;
      word_q     <= '0;
      rs_list_q  <= '0;
      init_q     <= 1'b0;
      lcd_data_q <= 8'h00;
      lcd_rs_q   <= 1'b0;
      lcd_e_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      rs_list_q  <= rs_list_d;
      init_q     <= init_d;
      lcd_data_q <= lcd_data_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_e_q    <= lcd_e_d;
      done_q     <= done_d;
    end
  end

  assign lcd_data = lcd_data_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = lcd_e_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lcd_escritor.sv
// Directed testbench for lcd_escritor: checks each enable pulse's byte, RS and
// width, end-to-end done latency, start locking and mid-transfer reset abort.
module tb_lcd_escritor;

   localparam int E_SETUP = 2;
   localparam int E_PULSE = 4;
   localparam int CMD_W   = 10;
   localparam int LONG_W  = 50;
   localparam int PWR_W   = 100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [87:0] palavra;
   logic [10:0] RS_list;
   logic [7:0]  lcd_data;
   logic        lcd_rs;
   logic        lcd_rw;
   logic        lcd_e;
   logic        busy;
   logic        done;

   lcd_escritor #(
      .E_SETUP_CYC(E_SETUP),
      .E_PULSE_CYC(E_PULSE),
      .CMD_WAIT_CYC(CMD_W),
      .LONG_WAIT_CYC(LONG_W),
      .POWERUP_WAIT_CYC(PWR_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .palavra(palavra),
      .RS_list(RS_list),
      .lcd_data(lcd_data),
      .lcd_rs(lcd_rs),
      .lcd_rw(lcd_rw),
      .lcd_e(lcd_e),
      .busy(busy),
      .done(done)
   );

   // Free-running clock and a count of rising edges used for latency measurement.
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [7:0] pdata[$];
   logic       prs[$];
   int         plen[$];
   bit         pstable[$];
   int         doneCount = 0;

`ifdef LCD_INIT_EN
   localparam bit BUSY_AFTER_RESET = 1'b1;
`else
   localparam bit BUSY_AFTER_RESET = 1'b0;
`endif

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Pulse monitor: records byte, RS, width and setup-stability of every lcd_e pulse.
   initial begin : monitor
      logic       ePrev;
      logic [7:0] prevData;
      logic       prevRs;
      logic [7:0] curData;
      logic       curRs;
      int         curLen;
      bit         curOk;
      ePrev    = 1'b0;
      prevData = 8'h00;
      prevRs   = 1'b0;
      curData  = 8'h00;
      curRs    = 1'b0;
      curLen   = 0;
      curOk    = 1'b0;
      forever begin
         @(negedge clk);
         if (lcd_e === 1'b1) begin
            if (!ePrev) begin
               curData = lcd_data;
               curRs   = lcd_rs;
               curLen  = 0;
               curOk   = (prevData === lcd_data) && (prevRs === lcd_rs);
            end
            curLen++;
            if (lcd_data !== curData || lcd_rs !== curRs) curOk = 1'b0;
         end else if (ePrev) begin
            pdata.push_back(curData);
            prs.push_back(curRs);
            plen.push_back(curLen);
            pstable.push_back(curOk);
         end
         if (done === 1'b1) doneCount++;
         ePrev    = (lcd_e === 1'b1);
         prevData = lcd_data;
         prevRs   = lcd_rs;
      end
   end

   function automatic logic [87:0] packWord(input logic [7:0] b [11]);
      logic [87:0] w;
      w = '0;
      for (int k = 0; k < 11; k++) w[8*k +: 8] = b[k];
      return w;
   endfunction

   int startCyc;

   task automatic clearPulses();
      pdata.delete();
      prs.delete();
      plen.delete();
      pstable.delete();
   endtask

   // Raises start for one cycle (or leaves it high when hold is set).
   task automatic applyStimulus(input logic [87:0] word, input logic [10:0] rs, input bit hold);
      clearPulses();
      @(negedge clk);
      palavra  = word;
      RS_list  = rs;
      start    = 1'b1;
      startCyc = cyc + 1;
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int budget, output int doneAt);
      doneAt = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            doneAt = cyc;
            break;
         end
      end
      if (doneAt < 0) checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic waitBusyLow(input string tag, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput({tag, "_busy_fall"}, 32'(seen), 32'd1);
   endtask

   task automatic checkWord(input string tag, input logic [7:0] eb [11], input logic [10:0] ers);
      int badShape;
      badShape = 0;
      checkOutput({tag, "_pulse_count"}, 32'(pdata.size()), 32'd11);
      for (int i = 0; i < 11; i++) begin
         if (i < pdata.size()) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(pdata[i]), 32'(eb[i]));
            checkOutput($sformatf("%s_rs%0d", tag, i), 32'(prs[i]), 32'(ers[i]));
            if (plen[i] != E_PULSE || !pstable[i]) badShape++;
         end
      end
      checkOutput({tag, "_bad_pulse_shape"}, 32'(badShape), 32'd0);
   endtask

   logic [7:0] loadB  [11] = '{8'h4C, 8'h4F, 8'h41, 8'h44, 8'h89, 8'h5B, 8'h31, 8'h30, 8'h31, 8'h30, 8'h5D};
   logic [7:0] addB   [11] = '{8'h41, 8'h44, 8'h44, 8'h20, 8'h31, 8'h2B, 8'h32, 8'h3D, 8'h33, 8'h20, 8'h02};
   logic [7:0] clearB [11] = '{8'h43, 8'h4C, 8'h45, 8'h41, 8'h52, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};
   logic [7:0] altB   [11] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21, 8'h21, 8'h21, 8'h21, 8'h21, 8'h21};
   logic [10:0] loadRs  = 11'b11111101111;
   logic [10:0] addRs   = 11'b01111111111;
   logic [10:0] clearRs = 11'b00000011111;
   logic [10:0] altRs   = 11'b11111111111;

   // Directed sequence; expected latencies are 11*17+1, 10*17+57+1 and 5*17+6*57+1.
   initial begin : main
      int doneAt;
      int doneAt2;
      int latLoad;
      int latAdd;
      int rises;
      int dcSnap;
      bit found;
      logic ePrevMain;

      rst_n   = 1'b0;
      start   = 1'b0;
      palavra = '0;
      RS_list = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_lcd_data", 32'(lcd_data), 32'h00);
      checkOutput("reset_lcd_rs", 32'(lcd_rs), 32'd0);
      checkOutput("reset_lcd_rw", 32'(lcd_rw), 32'd0);
      checkOutput("reset_lcd_e", 32'(lcd_e), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'(BUSY_AFTER_RESET));
      rst_n = 1'b1;

`ifdef LCD_INIT_EN
      clearPulses();
      repeat (PWR_W) @(negedge clk);
      checkOutput("powerup_busy", 32'(busy), 32'd1);
      checkOutput("powerup_no_pulse", 32'(pdata.size()), 32'd0);
      waitBusyLow("init", 1000);
      checkOutput("init_pulse_count", 32'(pdata.size()), 32'd4);
      if (pdata.size() == 4) begin
         checkOutput("init_cmd0", 32'(pdata[0]), 32'h38);
         checkOutput("init_cmd1", 32'(pdata[1]), 32'h0C);
         checkOutput("init_cmd2", 32'(pdata[2]), 32'h06);
         checkOutput("init_cmd3", 32'(pdata[3]), 32'h01);
         checkOutput("init_rs", 32'({prs[0], prs[1], prs[2], prs[3]}), 32'd0);
         checkOutput("init_len", 32'(plen[0] + plen[1] + plen[2] + plen[3]), 32'(4 * E_PULSE));
      end
      checkOutput("init_no_done", 32'(doneCount), 32'd0);
`else
      @(negedge clk);
      checkOutput("idle_busy", 32'(busy), 32'd0);
`endif

      $display("[TB] LOAD word");
      applyStimulus(packWord(loadB), loadRs, 1'b0);
      checkOutput("load_busy", 32'(busy), 32'd1);
      waitDone("load", 400, doneAt);
      latLoad = doneAt - startCyc;
      checkOutput("load_latency", 32'(latLoad), 32'd188);
      checkOutput("load_busy_at_done", 32'(busy), 32'd0);
      checkWord("load", loadB, loadRs);

      $display("[TB] ADD word with trailing home command");
      applyStimulus(packWord(addB), addRs, 1'b0);
      waitDone("add", 400, doneAt);
      latAdd = doneAt - startCyc;
      checkOutput("add_latency", 32'(latAdd), 32'd228);
      checkOutput("add_extra_wait", 32'(latAdd - latLoad), 32'd40);
      checkWord("add", addB, addRs);

      $display("[TB] start held, palavra changed mid-transfer");
      applyStimulus(packWord(loadB), loadRs, 1'b1);
      repeat (50) @(negedge clk);
      palavra = packWord(altB);
      RS_list = altRs;
      waitDone("hold", 400, doneAt);
      checkOutput("hold_latency", 32'(doneAt - startCyc), 32'd188);
      checkWord("hold_first", loadB, loadRs);
      checkOutput("hold_busy_at_done", 32'(busy), 32'd0);
      clearPulses();
      @(negedge clk);
      checkOutput("hold_restart_busy", 32'(busy), 32'd1);
      start = 1'b0;
      waitDone("hold2", 400, doneAt2);
      checkOutput("hold_second_latency", 32'(doneAt2 - doneAt), 32'd189);
      checkWord("hold_second", altB, altRs);

      $display("[TB] reset during byte 5 enable pulse");
      applyStimulus(packWord(loadB), loadRs, 1'b0);
      rises     = 0;
      found     = 1'b0;
      ePrevMain = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (lcd_e === 1'b1 && !ePrevMain) rises++;
         ePrevMain = (lcd_e === 1'b1);
         if (rises == 6 && lcd_e === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("abort_reach_pulse5", 32'(found), 32'd1);
      dcSnap = doneCount;
      rst_n  = 1'b0;
      @(negedge clk);
      checkOutput("abort_lcd_e", 32'(lcd_e), 32'd0);
      checkOutput("abort_lcd_data", 32'(lcd_data), 32'h00);
      checkOutput("abort_busy", 32'(busy), 32'(BUSY_AFTER_RESET));
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      checkOutput("abort_no_done", 32'(doneCount - dcSnap), 32'd0);
`ifdef LCD_INIT_EN
      waitBusyLow("reinit", 1000);
`endif
      checkOutput("abort_idle_busy", 32'(busy), 32'd0);
      applyStimulus(packWord(loadB), loadRs, 1'b0);
      waitDone("after_abort", 400, doneAt);
      checkOutput("after_abort_latency", 32'(doneAt - startCyc), 32'd188);
      checkOutput("after_abort_first_byte", 32'(pdata.size() > 0 ? pdata[0] : 8'hFF), 32'h4C);

      $display("[TB] CLEAR word with six home commands");
      applyStimulus(packWord(clearB), clearRs, 1'b0);
      waitDone("clear", 800, doneAt);
      checkOutput("clear_latency", 32'(doneAt - startCyc), 32'd428);
      checkWord("clear", clearB, clearRs);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_escritor.md
Name: lcd_escritor

Overview:
- Downstream of the instruction-text encoder: takes its 11-byte word (palavra) plus per-byte RS flags (RS_list) and drives a HD44780-compatible 8-bit parallel LCD.
- Issues bytes 0..10 in order, with setup, enable-pulse and execution-wait timing, then signals done.
- Optionally runs the LCD power-up init sequence after reset.

Parameters:
- E_SETUP_CYC, 2, cycles lcd_rs/lcd_data are stable before lcd_e rises.
- E_PULSE_CYC, 25, cycles lcd_e is held high.
- CMD_WAIT_CYC, 2000, wait after a normal byte (40 us at 50 MHz).
- LONG_WAIT_CYC, 82000, wait after command 0x01 or 0x02 with RS=0.
- POWERUP_WAIT_CYC, 1000000, wait after reset before the init sequence.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request to send one word; sampled only when busy=0
- palavra  in  88  byte k at [8k+7:8k], k=0..10
- RS_list  in  11  bit k is RS for byte k (1=data, 0=command)
- lcd_data  out  8  LCD DB7..DB0
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  tied 0 (write only)
- lcd_e  out  1  LCD enable strobe
- busy  out  1  high while init or word transfer is in progress
- done  out  1  one-cycle pulse when the last byte's wait ends

Behaviour:
- Reset (rst_n=0 at a clk edge): lcd_data=0, lcd_rs=0, lcd_rw=0, lcd_e=0, busy=1 (INIT_EN build) or 0, done=0, byte index=0, counters=0, internal word and RS registers cleared.
- Reset asserted mid-transfer aborts the transfer on that edge: lcd_e=0 immediately, no done pulse, restart from POWERUP/IDLE.
- FSM states: POWERUP, INIT, IDLE, SETUP, PULSE, WAIT, NEXT, DONE.
- IDLE, busy=0: if start=1, latch palavra and RS_list into internal registers on that edge, set index=0, busy=1, go to SETUP.
  - start while busy=1 is ignored. Inputs are not sampled again until the next accepted start.
- SETUP: drive lcd_data=byte[index] and lcd_rs=RS[index]; lcd_e=0; stay E_SETUP_CYC cycles, then go to PULSE.
- PULSE: lcd_e=1 for exactly E_PULSE_CYC cycles; data and RS held; then lcd_e=0 and go to WAIT.
- WAIT: data and RS held. Wait is LONG_WAIT_CYC if RS=0 and byte is 0x01 or 0x02, otherwise CMD_WAIT_CYC. Then go to NEXT.
- NEXT: if index==10 go to DONE, else index+1 and go to SETUP. Index never wraps past 10.
- DONE: done=1 for one cycle, busy=0; next state IDLE.
  - A start in the DONE cycle is ignored. A start in the first IDLE cycle is accepted.
- A zero-valued delay parameter is treated as 1 cycle.
- Per-byte latency: E_SETUP_CYC + E_PULSE_CYC + wait + 1 (NEXT) cycles. From start edge to done pulse: 11 × per-byte latency + 1 cycle.
- All bytes are sent, including cursor-move (0x89, RS=0) and home (0x02, RS=0) commands.
- Counters are sized by $clog2 of the largest delay parameter, plus 1 bit.

Optional Feature:
- Macro: LCD_INIT_EN.
- Defined:
  - After reset: POWERUP waits POWERUP_WAIT_CYC with busy=1.
  - INIT then sends four RS=0 commands through the same SETUP/PULSE/WAIT path: 0x38, 0x0C, 0x06, 0x01. The 0x01 command uses LONG_WAIT_CYC.
  - Then IDLE, busy=0. done does not pulse for init.
- Undefined: POWERUP and INIT are absent. busy=0 and IDLE from the first cycle after reset release.

Test Plan:
- Parameters for all tests: E_SETUP_CYC=2, E_PULSE_CYC=4, CMD_WAIT_CYC=10, LONG_WAIT_CYC=50, POWERUP_WAIT_CYC=100.
- Reset check -> with rst_n=0 for 3 cycles, all outputs 0 and busy per build.
  - With LCD_INIT_EN: busy stays 1 for 100 cycles. Then exactly 4 lcd_e pulses of 4 cycles each with lcd_rs=0 and data 0x38, 0x0C, 0x06, 0x01. Then busy falls.
- LOAD word "LOAD", 0x89, "[1010]" with RS_list=11'b11111101111 -> 11 e-pulses in order 0x4C, 0x4F, 0x41, 0x44, 0x89, 0x5B, 0x31, 0x30, 0x31, 0x30, 0x5D.
  - Only byte 4 has lcd_rs=0.
  - done pulses exactly 11×17+1 cycles after the start edge.
- ADD word ending in 0x02 with RS_list[10]=0 -> last byte waits 50 cycles, not 10. done arrives 40 cycles later than in an all-data word.
- start held high for the whole transfer, with palavra changed mid-transfer -> only one word is sent, with the originally latched bytes. A second transfer begins only on the first IDLE cycle after done.
- rst_n pulled low during the PULSE of byte 5 -> lcd_e=0 on that edge, no done pulse. The block re-initialises and a new start sends byte 0 first.
- CLEAR word (0x43, 0x4C, 0x45, 0x41, 0x52, then 6×0x02 with RS=0) -> six long waits. Total time from start to done is 5×17 + 6×57 + 1 cycles.
